// File: rtl/vend_ctrl.sv
// Vending-machine sequencer: accumulates coin credit, vends on buy, and
// returns leftover credit as a train of unit change pulses.
module vend_ctrl #(
  parameter int PRICE      = 7,
  parameter int MAX_CREDIT = 20,
  parameter int CREDIT_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          coin_code,
  input  logic                coin_present,
  input  logic                buy,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_W   = CREDIT_W'(1);

  state_t              state_reg;
  logic [CREDIT_W-1:0] credit_reg;
  logic                dispense_reg;
  logic                change_reg;
  logic                reject_reg;
  logic                busy_reg;

  logic [2:0]          level_vec;
  logic [2:0]          event_vec;
  logic                coin_evt;
  logic                buy_evt;
  logic                cancel_evt;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   sum_next;
  logic                coin_fits;

  assign level_vec = {cancel, buy, coin_present};

  // Previous-value registers reset high so a level held across reset
  // release is not mistaken for a fresh press.
  for (genvar gi = 0; gi < 3; gi++) begin : g_edge
    logic prev_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_reg <= 1'b1;
      else        prev_reg <= level_vec[gi];
    end
    assign event_vec[gi] = level_vec[gi] & ~prev_reg;
  end

  assign coin_evt   = event_vec[0];
  assign buy_evt    = event_vec[1];
  assign cancel_evt = event_vec[2];

  always_comb begin
    coin_val = '0;
    case (coin_code)
      2'b00:   coin_val = (CREDIT_W+1)'(1);
      2'b01:   coin_val = (CREDIT_W+1)'(2);
      2'b10:   coin_val = (CREDIT_W+1)'(5);
      default: coin_val = (CREDIT_W+1)'(10);
    endcase
  end

  // One extra bit so the ceiling test can never be fooled by wrap-around.
  assign sum_next  = {1'b0, credit_reg} + coin_val;
  assign coin_fits = (sum_next <= MAX_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      credit_reg   <= '0;
      dispense_reg <= 1'b0;
      change_reg   <= 1'b0;
      reject_reg   <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      dispense_reg <= 1'b0;
      change_reg   <= 1'b0;
      reject_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          busy_reg <= 1'b0;
          if (coin_evt) begin
            if (coin_fits) begin
              credit_reg <= sum_next[CREDIT_W-1:0];
              state_reg  <= CREDIT;
            end else begin
              reject_reg <= 1'b1;
            end
          end
        end
        CREDIT: begin
          if (cancel_evt) begin
            state_reg  <= CHANGE;
            change_reg <= 1'b1;
            busy_reg   <= 1'b1;
            reject_reg <= coin_evt;
          end else if (buy_evt && (credit_reg >= PRICE_W)) begin
            state_reg    <= VEND;
            dispense_reg <= 1'b1;
            busy_reg     <= 1'b1;
            credit_reg   <= credit_reg - PRICE_W;
            reject_reg   <= coin_evt;
          end else if (coin_evt) begin
            if (coin_fits) credit_reg <= sum_next[CREDIT_W-1:0];
            else           reject_reg <= 1'b1;
          end
        end
        VEND: begin
          reject_reg <= coin_evt;
          if (credit_reg != '0) begin
            state_reg  <= CHANGE;
            change_reg <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        CHANGE: begin
          // Each cycle here is one pulse; leave on the edge credit hits zero.
          reject_reg <= coin_evt;
          credit_reg <= credit_reg - ONE_W;
          if (credit_reg == ONE_W) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            change_reg <= 1'b1;
          end
        end
        default: begin
          state_reg  <= IDLE;
          credit_reg <= '0;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign credit       = credit_reg;
  assign dispense     = dispense_reg;
  assign change_pulse = change_reg;
  assign coin_reject  = reject_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl with hand-computed expectations.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] coin_code = 2'b00;
  logic       coin_present = 1'b0;
  logic       buy = 1'b0;
  logic       cancel = 1'b0;
  logic [4:0] credit;
  logic       dispense;
  logic       change_pulse;
  logic       coin_reject;
  logic       busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  vend_ctrl #(.PRICE(7), .MAX_CREDIT(20), .CREDIT_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_code    (coin_code),
    .coin_present (coin_present),
    .buy          (buy),
    .cancel       (cancel),
    .credit       (credit),
    .dispense     (dispense),
    .change_pulse (change_pulse),
    .coin_reject  (coin_reject),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_coin(input logic [1:0] code);
    coin_code    = code;
    coin_present = 1'b1;
    tick();
    coin_present = 1'b0;
    tick();
  endtask

  // Counts change pulses and dispenses from the current cycle until busy drops.
  task automatic count_pulses(output int n, output int d, output int timeout);
    n = 0; d = 0; timeout = 1;
    for (int i = 0; i < 64; i++) begin
      if (change_pulse) n++;
      if (dispense) d++;
      if (!busy) begin timeout = 0; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    int n, d, t, seen;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      coin_code    = 2'($urandom_range(0, 3));
      coin_present = 1'($urandom_range(0, 1));
      buy          = 1'($urandom_range(0, 1));
      cancel       = 1'($urandom_range(0, 1));
      tick();
    end
    total_cnt++;
    if ({credit, dispense, change_pulse, coin_reject, busy} !== 9'd0)
      $display("FAIL reset_outputs: got %b want 0", {credit, dispense, change_pulse, coin_reject, busy});
    else pass_cnt++;
    buy = 1'b1; coin_present = 1'b1; coin_code = 2'b11; cancel = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick(); tick(); tick();
    total_cnt++;
    if (credit !== 5'd0) $display("FAIL reset_held_coin: credit got %0d want 0", credit);
    else pass_cnt++;
    coin_present = 1'b0;
    tick();
    drop_coin(2'b11);
    total_cnt++;
    if (credit !== 5'd10) $display("FAIL reset_coin10: credit got %0d want 10", credit);
    else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (dispense) seen++;
      tick();
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL reset_held_buy: dispense cycles got %0d want 0", seen);
    else pass_cnt++;
    buy = 1'b0; tick();
    buy = 1'b1; tick();
    total_cnt++;
    if ({dispense, credit} !== {1'b1, 5'd3})
      $display("FAIL reset_rebuy: dispense/credit got %0d/%0d want 1/3", dispense, credit);
    else pass_cnt++;
    buy = 1'b0; tick();
    count_pulses(n, d, t);
    total_cnt++;
    if (n !== 3 || t !== 0) $display("FAIL reset_change: pulses got %0d want 3 (timeout %0d)", n, t);
    else pass_cnt++;
  endtask

  task automatic test_exact_purchase();
    int n, d, t;
    drop_coin(2'b11);
    total_cnt++;
    if (credit !== 5'd10) $display("FAIL exact_coin10: credit got %0d want 10", credit);
    else pass_cnt++;
    drop_coin(2'b01);
    total_cnt++;
    if (credit !== 5'd12) $display("FAIL exact_coin2: credit got %0d want 12", credit);
    else pass_cnt++;
    buy = 1'b1; tick();
    total_cnt++;
    if ({dispense, change_pulse, busy, credit} !== {3'b101, 5'd5})
      $display("FAIL exact_vend: d/c/b/credit got %b/%0d want 101/5", {dispense, change_pulse, busy}, credit);
    else pass_cnt++;
    buy = 1'b0; tick();
    total_cnt++;
    if ({dispense, change_pulse, credit} !== {2'b01, 5'd5})
      $display("FAIL exact_first_change: d/c/credit got %b/%0d want 01/5", {dispense, change_pulse}, credit);
    else pass_cnt++;
    count_pulses(n, d, t);
    total_cnt++;
    if (n !== 5 || d !== 0 || t !== 0)
      $display("FAIL exact_change: pulses/dispense got %0d/%0d want 5/0", n, d);
    else pass_cnt++;
    total_cnt++;
    if ({credit, busy, change_pulse} !== 7'd0)
      $display("FAIL exact_idle: credit/busy/pulse got %0d/%0d/%0d want 0/0/0", credit, busy, change_pulse);
    else pass_cnt++;
  endtask

  task automatic test_insufficient();
    int n, d, t;
    drop_coin(2'b10);
    buy = 1'b1; tick();
    total_cnt++;
    if ({dispense, busy, credit} !== {2'b00, 5'd5})
      $display("FAIL insuff_buy: dispense/busy/credit got %0d/%0d/%0d want 0/0/5", dispense, busy, credit);
    else pass_cnt++;
    buy = 1'b0; tick();
    cancel = 1'b1; tick();
    total_cnt++;
    if ({change_pulse, busy} !== 2'b11)
      $display("FAIL insuff_cancel: pulse/busy got %b want 11", {change_pulse, busy});
    else pass_cnt++;
    cancel = 1'b0;
    count_pulses(n, d, t);
    total_cnt++;
    if (n !== 5 || d !== 0 || t !== 0 || credit !== 5'd0)
      $display("FAIL insuff_refund: pulses/credit got %0d/%0d want 5/0", n, credit);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int n, d, t;
    drop_coin(2'b11);
    drop_coin(2'b11);
    total_cnt++;
    if (credit !== 5'd20) $display("FAIL ovf_fill: credit got %0d want 20", credit);
    else pass_cnt++;
    coin_code = 2'b00; coin_present = 1'b1; tick();
    total_cnt++;
    if ({coin_reject, credit} !== {1'b1, 5'd20})
      $display("FAIL ovf_reject: reject/credit got %0d/%0d want 1/20", coin_reject, credit);
    else pass_cnt++;
    coin_present = 1'b0; tick();
    total_cnt++;
    if ({coin_reject, credit} !== {1'b0, 5'd20})
      $display("FAIL ovf_reject_end: reject/credit got %0d/%0d want 0/20", coin_reject, credit);
    else pass_cnt++;
    buy = 1'b1; tick();
    total_cnt++;
    if ({dispense, credit} !== {1'b1, 5'd13})
      $display("FAIL ovf_vend: dispense/credit got %0d/%0d want 1/13", dispense, credit);
    else pass_cnt++;
    buy = 1'b0; tick();
    count_pulses(n, d, t);
    total_cnt++;
    if (n !== 13 || d !== 0 || t !== 0)
      $display("FAIL ovf_change: pulses/dispense got %0d/%0d want 13/0", n, d);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int n, d, t;
    drop_coin(2'b11);
    buy = 1'b1; cancel = 1'b1; coin_code = 2'b00; coin_present = 1'b1;
    tick();
    total_cnt++;
    if ({dispense, coin_reject, change_pulse} !== 3'b011)
      $display("FAIL simul_edge: disp/rej/pulse got %b want 011", {dispense, coin_reject, change_pulse});
    else pass_cnt++;
    buy = 1'b0; cancel = 1'b0; coin_present = 1'b0;
    tick();
    total_cnt++;
    if (coin_reject !== 1'b0) $display("FAIL simul_reject_once: reject got %0d want 0", coin_reject);
    else pass_cnt++;
    count_pulses(n, d, t);
    total_cnt++;
    if (n + 1 !== 10 || d !== 0 || t !== 0)
      $display("FAIL simul_change: pulses/dispense got %0d/%0d want 10/0", n + 1, d);
    else pass_cnt++;
    drop_coin(2'b10);
    cancel = 1'b1; tick();
    cancel = 1'b0; coin_code = 2'b01; coin_present = 1'b1; tick();
    total_cnt++;
    if ({coin_reject, change_pulse, credit} !== {2'b11, 5'd4})
      $display("FAIL change_coin: rej/pulse/credit got %b/%0d want 11/4", {coin_reject, change_pulse}, credit);
    else pass_cnt++;
    coin_present = 1'b0; tick();
    count_pulses(n, d, t);
    total_cnt++;
    if (n + 2 !== 5 || t !== 0)
      $display("FAIL change_coin_count: pulses got %0d want 5", n + 2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    drop_coin(2'b10);
    drop_coin(2'b01);
    drop_coin(2'b00);
    total_cnt++;
    if (credit !== 5'd8) $display("FAIL mid_fill: credit got %0d want 8", credit);
    else pass_cnt++;
    cancel = 1'b1; tick();
    cancel = 1'b0; tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({credit, dispense, change_pulse, coin_reject, busy} !== 9'd0)
      $display("FAIL mid_async: outputs got %b want 0", {credit, dispense, change_pulse, coin_reject, busy});
    else pass_cnt++;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (change_pulse) n++;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (change_pulse || busy) n++;
    end
    total_cnt++;
    if (n !== 0 || credit !== 5'd0)
      $display("FAIL mid_quiet: stray pulse cycles/credit got %0d/%0d want 0/0", n, credit);
    else pass_cnt++;
    drop_coin(2'b00);
    total_cnt++;
    if ({credit, coin_reject} !== {5'd1, 1'b0})
      $display("FAIL mid_idle_coin: credit/reject got %0d/%0d want 1/0", credit, coin_reject);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_exact_purchase();
    test_insufficient();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
Name: vend_ctrl

Overview:
- Vending-machine sequencing FSM that consumes the 2-bit coin code produced by the 4-to-2 switch encoder.
- Accumulates credit from coins and accepts buy/cancel requests.
- Issues a single dispense pulse, then returns any remaining credit as a train of unit change pulses.
- Sits between the switch encoder and the dispenser/change-return drivers. Drives the credit display value.

Parameters:
- PRICE, 7, product price in credit units; must satisfy 1 <= PRICE <= MAX_CREDIT.
- MAX_CREDIT, 20, credit ceiling; a coin that would exceed it is rejected.
- CREDIT_W, 5, credit register width; must satisfy MAX_CREDIT < 2**CREDIT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coin_code  in  2  encoder output. Coin values: 00 = 1 unit, 01 = 2, 10 = 5, 11 = 10.
- coin_present  in  1  high while any coin switch is active; already synchronous to clk.
- buy  in  1  purchase request, level; synchronous to clk.
- cancel  in  1  refund request, level; synchronous to clk.
- credit  out  CREDIT_W  current credit.
- dispense  out  1  one-cycle vend pulse.
- change_pulse  out  1  one pulse per unit of credit returned.
- coin_reject  out  1  one-cycle pulse when a coin is refused.
- busy  out  1  high in VEND and CHANGE.

Behaviour:
- Reset (async assert): state IDLE; credit, dispense, change_pulse, coin_reject and busy all 0. Any in-flight credit is discarded.
- Edge detection:
  - coin_present, buy and cancel are each registered.
  - An event is input high while its registered previous value is 0.
  - The previous-value registers reset to 1, so an input held through reset release produces no event until it is released and pressed again.
- All outputs are registered. An event sampled at clock edge k affects outputs from edge k onward; no output pulse appears later than one cycle after its cause.
- IDLE: credit == 0, busy = 0.
  - Coin event: credit <= value; go to CREDIT.
  - Buy and cancel are ignored.
- CREDIT: same-cycle priority is cancel > buy > coin.
  - Cancel event: go to CHANGE.
  - Buy event with credit >= PRICE: go to VEND.
  - Buy event with credit < PRICE: ignored; credit unchanged.
  - Coin event with credit + value <= MAX_CREDIT: credit updated.
  - Coin event with credit + value > MAX_CREDIT: coin_reject pulse; credit unchanged.
  - A coin event in the same cycle as an acted-on buy or cancel: coin_reject pulse; coin not added.
  - Addition is computed in CREDIT_W+1 bits; wrap-around never occurs.
- VEND: lasts exactly one cycle.
  - dispense = 1 and credit <= credit - PRICE.
  - Next state is CHANGE if the remainder > 0, else IDLE.
- CHANGE: on each cycle, change_pulse = 1 and credit decrements by 1.
  - The transition to IDLE occurs on the edge where credit reaches 0.
  - Pulse count equals the credit on entry, with pulses in back-to-back cycles.
- Coin events in VEND or CHANGE produce a coin_reject pulse and are not added. Buy and cancel events there are ignored.
- dispense, change_pulse and coin_reject are never high in IDLE after reset.
- dispense and change_pulse are never high in the same cycle.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> all outputs 0. Release with buy held high -> no dispense until buy is released and pressed again.
- Exact purchase path: coins 10 and 2 (release between) -> credit 10 then 12. Buy -> dispense for 1 cycle, credit 5, then 5 consecutive change_pulse cycles, credit 0, busy low, state IDLE.
- Insufficient credit: coin 5, buy -> no dispense, credit stays 5. Cancel -> exactly 5 change_pulse, credit 0.
- Overflow: coins 10 and 10 -> credit 20. Coin 1 -> coin_reject for 1 cycle, credit stays 20. A subsequent buy -> dispense, then 13 change pulses.
- Simultaneous events: credit 10, with buy, cancel and a coin rising in the same cycle -> no dispense, one coin_reject, 10 change pulses. A coin event during CHANGE -> coin_reject, pulse count unchanged.
- Reset mid-operation: assert rst_n during CHANGE after 3 of 8 pulses -> outputs 0 immediately (asynchronously), no further pulses, and state IDLE after release.
